// File: rtl/cmos_frame_writer.sv
// cmos_frame_writer: buffers the RGB565 pixel stream and writes it to SDRAM
// in fixed bursts, alternating between two ping-pong frame banks.
module cmos_frame_writer #(
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 32,
  parameter int FRAME_WORDS = 130560,
  parameter int ADDR_W      = 22
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFRAME_VALID,
  input  logic              iPIX_EN,
  input  logic [15:0]       iPIX_DATA,
  output logic              oWR_REQ,
  output logic [ADDR_W-1:0] oWR_ADDR,
  input  logic              iWR_ACK,
  input  logic              iWR_DATA_REQ,
  output logic [15:0]       oWR_DATA,
  output logic              oRD_BANK,
  output logic              oFRAME_DONE,
  output logic              oOVERFLOW
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FRAME_WORDS + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int OW = ADDR_W - 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_BURST = CW'(BURST_LEN);
  localparam logic [FW-1:0] F_FRAME = FW'(FRAME_WORDS);
  localparam logic [FW-1:0] F_BURST = FW'(BURST_LEN);
  localparam logic [OW-1:0] O_BURST = OW'(BURST_LEN);
  localparam logic [BW-1:0] B_LAST  = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [FW-1:0]     r_pushed;
  logic [FW-1:0]     r_written;
  logic [OW-1:0]     r_offset;
  logic [BW-1:0]     r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_fv_d;
  logic              r_restart;
  logic              r_rd_bank;
  logic              r_done;
  logic              r_ovf;

  logic              w_rise;
  logic              w_full;
  logic              w_try;
  logic              w_push;
  logic              w_req;
  logic              w_load;
  logic              w_clear;
  logic              w_pop;
  logic              w_last;
  logic [FW-1:0]     w_written_nxt;

  assign w_rise        = iFRAME_VALID & ~r_fv_d;
  assign w_full        = (r_count == C_DEPTH);
  assign w_try         = iPIX_EN & iFRAME_VALID & (r_pushed < F_FRAME)
                       & ~r_restart & ~w_rise;
  assign w_push        = w_try & ~w_full;
  assign w_written_nxt = r_written + F_BURST;

  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (!r_restart && r_count >= C_BURST) w_next = S_REQ;
      S_REQ:  if (iWR_ACK) w_next = S_DATA;
      S_DATA: if (iWR_DATA_REQ && r_beat == B_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req   = 1'b0;
    w_load  = 1'b0;
    w_clear = 1'b0;
    w_pop   = 1'b0;
    w_last  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clear = r_restart;
        w_load  = ~r_restart & (r_count >= C_BURST);
      end
      S_REQ:  w_req = 1'b1;
      S_DATA: begin
        w_pop  = iWR_DATA_REQ;
        w_last = iWR_DATA_REQ & (r_beat == B_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (w_push) r_mem[r_wptr] <= iPIX_DATA;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_fv_d    <= 1'b0;
      r_restart <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pushed  <= '0;
      r_written <= '0;
      r_offset  <= '0;
      r_beat    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_rd_bank <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_fv_d <= iFRAME_VALID;
      r_done <= 1'b0;
      if (w_rise)       r_restart <= 1'b1;
      else if (w_clear) r_restart <= 1'b0;
      if (w_rise)       r_pushed <= '0;
      else if (w_push)  r_pushed <= r_pushed + FW'(1);
      if (w_try & w_full) r_ovf <= 1'b1;
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
        r_beat <= w_last ? '0 : r_beat + BW'(1);
      end
      // A pending restart flushes the FIFO only once the bus is idle
      if (w_clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
      if (w_load) r_addr <= {~r_rd_bank, r_offset};
      if (w_last) begin
        if (w_written_nxt == F_FRAME) begin
          r_rd_bank <= ~r_rd_bank;
          r_done    <= 1'b1;
          r_offset  <= '0;
          r_written <= '0;
        end else begin
          r_offset  <= r_offset + O_BURST;
          r_written <= w_written_nxt;
        end
      end
      if (w_clear) begin
        r_offset  <= '0;
        r_written <= '0;
      end
    end
  end

  assign oWR_REQ     = w_req;
  assign oWR_ADDR    = r_addr;
  assign oWR_DATA    = r_data;
  assign oRD_BANK    = r_rd_bank;
  assign oFRAME_DONE = r_done;
  assign oOVERFLOW   = r_ovf;

endmodule

// File: tb/tb_cmos_frame_writer.sv
// tb_cmos_frame_writer: directed and randomized stimulus checked each cycle
// against a queue-based behavioural model of the frame writer.
module tb_cmos_frame_writer;

  localparam int BL    = 8;
  localparam int DEPTH = 16;
  localparam int FWDS  = 24;
  localparam int AW    = 8;
  localparam int OMOD  = 1 << (AW - 1);

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iFRAME_VALID = 1'b0;
  logic          iPIX_EN = 1'b0;
  logic [15:0]   iPIX_DATA = '0;
  logic          iWR_ACK = 1'b0;
  logic          iWR_DATA_REQ = 1'b0;
  logic          oWR_REQ;
  logic [AW-1:0] oWR_ADDR;
  logic [15:0]   oWR_DATA;
  logic          oRD_BANK;
  logic          oFRAME_DONE;
  logic          oOVERFLOW;

  always #5 iCLK = ~iCLK;

  cmos_frame_writer #(
    .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .FRAME_WORDS(FWDS), .ADDR_W(AW)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iFRAME_VALID(iFRAME_VALID),
    .iPIX_EN(iPIX_EN), .iPIX_DATA(iPIX_DATA),
    .oWR_REQ(oWR_REQ), .oWR_ADDR(oWR_ADDR), .iWR_ACK(iWR_ACK),
    .iWR_DATA_REQ(iWR_DATA_REQ), .oWR_DATA(oWR_DATA),
    .oRD_BANK(oRD_BANK), .oFRAME_DONE(oFRAME_DONE), .oOVERFLOW(oOVERFLOW)
  );

  // behavioural model: FIFO as a queue, counters as plain ints
  logic [15:0]   q[$];
  int            m_pushed, m_offset, m_written, m_beats, m_phase, cyc;
  bit            m_fvp, m_restart, m_bank, chk_en;
  logic          m_req, m_done, m_ovf;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_data;

  always @(posedge iCLK) begin : model
    bit rise, rpre;
    int sz;
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL global_timeout cycles=%0d limit=60000", cyc);
      $fatal(1);
    end
    if (iRST) begin
      q.delete();
      m_fvp = 0; m_restart = 0; m_phase = 0; m_beats = 0;
      m_pushed = 0; m_offset = 0; m_written = 0; m_bank = 0;
      m_req = 0; m_addr = '0; m_data = '0; m_done = 0; m_ovf = 0;
      chk_en = 1;
    end else begin
      rise = iFRAME_VALID && !m_fvp;
      rpre = m_restart;
      sz = q.size();
      m_done = 0;
      if (m_phase == 0) begin
        if (m_restart) begin
          q.delete(); m_offset = 0; m_written = 0; m_restart = 0;
        end else if (sz >= BL) begin
          m_phase = 1;
          m_addr = AW'((m_bank ? 0 : OMOD) + m_offset);
        end
      end else if (m_phase == 1) begin
        if (iWR_ACK) m_phase = 2;
      end else if (iWR_DATA_REQ) begin
        m_data = q.pop_front();
        m_beats++;
        if (m_beats == BL) begin
          m_beats = 0; m_phase = 0;
          m_written += BL;
          m_offset = (m_offset + BL) % OMOD;
          if (m_written == FWDS) begin
            m_bank = !m_bank; m_done = 1; m_offset = 0; m_written = 0;
          end
        end
      end
      if (iPIX_EN && iFRAME_VALID && m_pushed < FWDS && !rpre && !rise) begin
        if (sz == DEPTH) m_ovf = 1;
        else begin q.push_back(iPIX_DATA); m_pushed++; end
      end
      if (rise) begin m_restart = 1; m_pushed = 0; end
      m_fvp = iFRAME_VALID;
      m_req = (m_phase == 1);
    end
  end

  int n_vec = 0, n_bad = 0;
  logic [AW-1:0] srv_addr;
  logic [15:0]   srv_data [BL];
  bit            srv_done, feed_done;

  task automatic cmp1(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(negedge iCLK);
    if (chk_en) begin
      cmp1("wr_req", oWR_REQ, m_req);
      cmp1("wr_addr", oWR_ADDR, m_addr);
      cmp1("wr_data", oWR_DATA, m_data);
      cmp1("rd_bank", oRD_BANK, m_bank);
      cmp1("frame_done", oFRAME_DONE, m_done);
      cmp1("overflow", oOVERFLOW, m_ovf);
    end
    @(posedge iCLK); #1;
  endtask

  task automatic pstep();
    @(posedge iCLK); #1;
  endtask

  task automatic adv(input bit quiet);
    if (quiet) pstep(); else step();
  endtask

  task automatic pix(input int n, input int start, input int gmax,
                     input bit quiet);
    for (int i = 0; i < n; i++) begin
      iPIX_EN = 1'b1;
      iPIX_DATA = (start < 0) ? 16'($urandom) : 16'(start + i);
      adv(quiet);
      iPIX_EN = 1'b0;
      repeat ($urandom_range(gmax, 0)) adv(quiet);
    end
  endtask

  task automatic fstart();
    iFRAME_VALID = 1'b0;
    step();
    iFRAME_VALID = 1'b1;
    repeat (3) step();
  endtask

  task automatic service(input int ack_dly, input int rs_after,
                         input bit rnd, input bit must);
    int t;
    t = 0;
    srv_done = 0;
    while (oWR_REQ !== 1'b1 && t < 300) begin step(); t++; end
    if (oWR_REQ !== 1'b1) begin
      if (must) begin
        n_vec++; n_bad++;
        $display("FAIL burst_timeout got=no_req exp=req t=%0t", $time);
      end
      return;
    end
    srv_addr = oWR_ADDR;
    repeat (ack_dly) step();
    iWR_ACK = 1'b1;
    step();
    iWR_ACK = 1'b0;
    for (int b = 0; b < BL; b++) begin
      if (rnd) repeat ($urandom_range(2, 0)) step();
      if (b == rs_after) begin
        iFRAME_VALID = 1'b0;
        step();
        iFRAME_VALID = 1'b1;
      end
      iWR_DATA_REQ = 1'b1;
      step();
      iWR_DATA_REQ = 1'b0;
      srv_data[b] = oWR_DATA;
      if (oFRAME_DONE) srv_done = 1;
    end
  endtask

  initial begin
    repeat (2) step();
    iRST = 1'b0;
    repeat (20) step();
    cmp1("idle_req", oWR_REQ, 0);
    cmp1("idle_bank", oRD_BANK, 0);
    cmp1("idle_ovf", oOVERFLOW, 0);

    fstart();
    pix(8, 1, 0, 0);
    cmp1("req_after_1", oWR_REQ, 0);
    step();
    cmp1("req_after_2", oWR_REQ, 1);
    service(3, -1, 0, 1);
    cmp1("b0_addr", srv_addr, 8'h80);
    for (int i = 0; i < BL; i++) cmp1("b0_data", srv_data[i], 16'(i + 1));
    pix(8, 9, 0, 0);
    service(1, -1, 0, 1);
    cmp1("b1_addr", srv_addr, 8'h88);
    pix(8, 17, 1, 0);
    service(0, -1, 0, 1);
    cmp1("b2_addr", srv_addr, 8'h90);
    cmp1("b2_done", srv_done, 1);
    cmp1("bank_flip", oRD_BANK, 1);

    fstart();
    pix(12, 50, 0, 0);
    service(2, -1, 0, 1);
    cmp1("short_addr", srv_addr, 8'h00);
    cmp1("short_done", srv_done, 0);
    repeat (10) step();
    cmp1("short_noreq", oWR_REQ, 0);
    iFRAME_VALID = 1'b0;
    repeat (3) step();
    cmp1("short_bank", oRD_BANK, 1);

    fstart();
    pix(8, 60, 0, 0);
    service(1, -1, 0, 1);
    cmp1("clr_addr", srv_addr, 8'h00);
    cmp1("clr_data", srv_data[0], 16'd60);
    pix(16, 70, 0, 0);
    service(1, 3, 0, 1);
    cmp1("rs_data3", srv_data[3], 16'd73);
    cmp1("rs_data7", srv_data[7], 16'd77);
    repeat (10) step();
    cmp1("rs_flushed", oWR_REQ, 0);
    pix(8, 90, 0, 0);
    service(0, -1, 0, 1);
    cmp1("rs_addr", srv_addr, 8'h00);
    cmp1("rs_new", srv_data[0], 16'd90);
    cmp1("pre_rand_ovf", oOVERFLOW, 0);

    feed_done = 0;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          iFRAME_VALID = 1'b0;
          repeat ($urandom_range(4, 1)) pstep();
          iFRAME_VALID = 1'b1;
          repeat ($urandom_range(3, 0)) pstep();
          pix($urandom_range(30, 6), -1, 3, 1);
        end
        iFRAME_VALID = 1'b0;
        feed_done = 1;
      end
      begin
        while (!feed_done) begin
          if (oWR_REQ === 1'b1) service($urandom_range(3, 0), -1, 1, 0);
          else step();
        end
      end
    join
    repeat (4) begin
      step(); step();
      if (oWR_REQ === 1'b1) service(1, -1, 1, 1);
    end

    fstart();
    pix(20, 100, 0, 0);
    cmp1("ovf_set", oOVERFLOW, 1);
    service(0, -1, 0, 1);
    cmp1("ovf_first", srv_data[0], 16'd100);
    service(0, -1, 0, 1);
    cmp1("ovf_last", srv_data[7], 16'd115);
    repeat (5) step();
    cmp1("ovf_sticky", oOVERFLOW, 1);
    cmp1("ovf_noreq", oWR_REQ, 0);

    fstart();
    pix(8, 200, 0, 0);
    step(); step();
    iWR_ACK = 1'b1;
    step();
    iWR_ACK = 1'b0;
    iWR_DATA_REQ = 1'b1;
    repeat (3) step();
    iWR_DATA_REQ = 1'b0;
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    cmp1("rst_req", oWR_REQ, 0);
    cmp1("rst_addr", oWR_ADDR, 0);
    cmp1("rst_data", oWR_DATA, 0);
    cmp1("rst_bank", oRD_BANK, 0);
    cmp1("rst_done", oFRAME_DONE, 0);
    cmp1("rst_ovf", oOVERFLOW, 0);
    repeat (3) step();
    pix(8, 300, 0, 0);
    service(1, -1, 0, 1);
    cmp1("post_rst_addr", srv_addr, 8'h80);
    cmp1("post_rst_data", srv_data[0], 16'd300);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
